// File: rtl/riscv_dmem_ctrl.sv
// Data-memory controller for a RISC-V core: one access at a time, fixed wait
// latency, byte/half/word lanes with sign/zero extension and fault detection.
module riscv_dmem_ctrl #(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        W_en,
  input  logic [31:0] addr,
  input  logic [2:0]  RW_type,
  input  logic [31:0] din,
  output logic        resp_valid,
  output logic [31:0] dout,
  output logic        err
);
  localparam int unsigned AW = $clog2(DEPTH_WORDS);
  localparam int unsigned CW = 4;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t          state, state_next;
  logic [CW-1:0]   cnt, cnt_next;
  logic            lat_we;
  logic [31:0]     lat_addr;
  logic [2:0]      lat_type;
  logic [31:0]     lat_din;
  logic [31:0]     mem [DEPTH_WORDS];

  logic            accept_c;
  logic            enter_resp_c;
  logic            acc_we;
  logic [31:0]     acc_addr;
  logic [2:0]      acc_type;
  logic [31:0]     acc_din;
  logic [AW-1:0]   acc_idx;
  logic            fault_c;
  logic [3:0]      be_c;
  logic [31:0]     wdata_c;
  logic [31:0]     word_c;
  logic [7:0]      byte_c;
  logic [15:0]     half_c;
  logic [31:0]     load_c;

  assign accept_c = req_valid && (state == IDLE);

  // With zero wait cycles RESP is entered on the accepting edge, before the
  // latched copy exists, so the live inputs describe the access there.
  always_comb begin
    acc_we   = lat_we;
    acc_addr = lat_addr;
    acc_type = lat_type;
    acc_din  = lat_din;
    if (state == IDLE) begin
      acc_we   = W_en;
      acc_addr = addr;
      acc_type = RW_type;
      acc_din  = din;
    end
  end

  assign acc_idx = acc_addr[AW+1:2];

  // Misalignment, reserved funct3 encodings and out-of-range addresses.
  always_comb begin
    fault_c = 1'b0;
    case (acc_type)
      3'b000, 3'b100: fault_c = 1'b0;
      3'b001, 3'b101: fault_c = acc_addr[0];
      3'b010:         fault_c = |acc_addr[1:0];
      default:        fault_c = 1'b1;
    endcase
    if (|acc_addr[31:AW+2]) fault_c = 1'b1;
  end

  always_comb begin
    be_c    = 4'b1111;
    wdata_c = acc_din;
    case (acc_type[1:0])
      2'b00: begin
        be_c    = 4'b0001 << acc_addr[1:0];
        wdata_c = {4{acc_din[7:0]}};
      end
      2'b01: begin
        be_c    = acc_addr[1] ? 4'b1100 : 4'b0011;
        wdata_c = {2{acc_din[15:0]}};
      end
      default: begin
        be_c    = 4'b1111;
        wdata_c = acc_din;
      end
    endcase
  end

  always_comb begin
    word_c = mem[acc_idx];
    case (acc_addr[1:0])
      2'd0:    byte_c = word_c[7:0];
      2'd1:    byte_c = word_c[15:8];
      2'd2:    byte_c = word_c[23:16];
      default: byte_c = word_c[31:24];
    endcase
    half_c = acc_addr[1] ? word_c[31:16] : word_c[15:0];
    case (acc_type)
      3'b000:  load_c = {{24{byte_c[7]}}, byte_c};
      3'b001:  load_c = {{16{half_c[15]}}, half_c};
      3'b100:  load_c = {24'd0, byte_c};
      3'b101:  load_c = {16'd0, half_c};
      default: load_c = word_c;
    endcase
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    case (state)
      IDLE: begin
        if (accept_c) begin
          if (WAIT_CYCLES == 0) begin
            state_next = RESP;
          end else begin
            state_next = WAIT;
            cnt_next   = CW'(WAIT_CYCLES - 1);
          end
        end
      end
      WAIT: begin
        if (cnt == '0) state_next = RESP;
        else           cnt_next   = cnt - CW'(1);
      end
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign enter_resp_c = (state_next == RESP) && (state != RESP);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      dout       <= '0;
      err        <= 1'b0;
      lat_we     <= 1'b0;
      lat_addr   <= '0;
      lat_type   <= '0;
      lat_din    <= '0;
    end else begin
      state      <= state_next;
      cnt        <= cnt_next;
      req_ready  <= (state_next == IDLE);
      resp_valid <= (state_next == RESP);
      if (accept_c) begin
        lat_we   <= W_en;
        lat_addr <= addr;
        lat_type <= RW_type;
        lat_din  <= din;
      end
      if (enter_resp_c) begin
        err  <= fault_c;
        dout <= (fault_c || acc_we) ? 32'd0 : load_c;
      end
    end
  end

  // Array is deliberately not reset; writes are blocked while rst_n is low.
  always_ff @(posedge clk) begin
    if (rst_n && enter_resp_c && acc_we && !fault_c) begin
      for (int i = 0; i < 4; i++) begin
        if (be_c[i]) mem[acc_idx][8*i +: 8] <= wdata_c[8*i +: 8];
      end
    end
  end

endmodule
